// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: decodes instructions into a registered field/control bundle,
// buffers them in a small FIFO and inserts one bubble per load-use hazard.
// Optional illegal-instruction flag is enabled with `define DECODE_ILLEGAL_EN.
module decode_stage_pipe #(
   parameter int BUF_DEPTH = 2,
   parameter int IMM_W     = 32,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [6:0]       opcode,
   output logic [2:0]       funct3,
   output logic [6:0]       funct7,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [IMM_W-1:0] imm,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic             mem_write,
   output logic             reg_write,
   output logic             branch,
   output logic             jump,
`ifdef DECODE_ILLEGAL_EN
   output logic             illegal,
`endif
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_BITS = $clog2(BUF_DEPTH + 1);
   localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(BUF_DEPTH);

   typedef struct packed {
      logic [6:0]       opcode;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [IMM_W-1:0] imm;
      logic             alu_src;
      logic             mem_to_reg;
      logic             mem_write;
      logic             reg_write;
      logic             branch;
      logic             jump;
`ifdef DECODE_ILLEGAL_EN
      logic             illegal;
`endif
   } bundle_t;

   bundle_t             dec;
   logic [31:0]         imm32;
   bundle_t             mem [BUF_DEPTH];
   bundle_t             head_q;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    rd_ptr_next;
   logic [CNT_BITS-1:0] count;
   logic [CNT_BITS-1:0] count_next;
   logic [CNT_BITS-1:0] remain;
   logic                load_rec_valid;
   logic [4:0]          load_rec_rd;
   logic                hazard;
   logic                full;
   logic                push;
   logic                pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Field extraction and control generation; fields a format does not use stay zero.
   always_comb begin
      dec        = '0;
      imm32      = '0;
      dec.opcode = instruction[6:0];
      case (instruction[6:0])
         OP_R: begin
            dec.funct3    = instruction[14:12];
            dec.funct7    = instruction[31:25];
            dec.rs1       = instruction[19:15];
            dec.rs2       = instruction[24:20];
            dec.rd        = instruction[11:7];
            dec.reg_write = 1'b1;
         end
         OP_I, OP_LOAD, OP_JALR: begin
            dec.funct3    = instruction[14:12];
            dec.rs1       = instruction[19:15];
            dec.rd        = instruction[11:7];
            imm32         = {{20{instruction[31]}}, instruction[31:20]};
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            if (instruction[6:0] == OP_LOAD)
               dec.mem_to_reg = 1'b1;
            if (instruction[6:0] == OP_JALR)
               dec.jump = 1'b1;
            if (instruction[6:0] == OP_I &&
                (instruction[14:12] == 3'b001 || instruction[14:12] == 3'b101))
               dec.funct7 = instruction[31:25];
         end
         OP_S: begin
            dec.funct3    = instruction[14:12];
            dec.rs1       = instruction[19:15];
            dec.rs2       = instruction[24:20];
            imm32         = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         OP_B: begin
            dec.funct3  = instruction[14:12];
            dec.rs1     = instruction[19:15];
            dec.rs2     = instruction[24:20];
            imm32       = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                           instruction[11:8], 1'b0};
            dec.alu_src = 1'b1;
            dec.branch  = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec.rd        = instruction[11:7];
            imm32         = {instruction[31:12], 12'b0};
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OP_JAL: begin
            dec.rd        = instruction[11:7];
            imm32         = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                             instruction[30:21], 1'b0};
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
         end
         default: begin
            dec.funct3 = instruction[14:12];
            dec.rs1    = instruction[19:15];
            dec.rd     = instruction[11:7];
`ifdef DECODE_ILLEGAL_EN
            dec.illegal = 1'b1;
`endif
         end
      endcase
      dec.imm = IMM_W'($signed(imm32));
`ifdef DECODE_ILLEGAL_EN
      // Only funct7 0x00 and 0x20 exist, and 0x20 only pairs with SUB and SRA.
      if (instruction[6:0] == OP_R) begin
         if (instruction[31:25] != 7'b0000000 && instruction[31:25] != 7'b0100000)
            dec.illegal = 1'b1;
         if (instruction[31:25] == 7'b0100000 &&
             instruction[14:12] != 3'b000 && instruction[14:12] != 3'b101)
            dec.illegal = 1'b1;
      end
      if (dec.illegal) begin
         dec.reg_write = 1'b0;
         dec.mem_write = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
      end
`endif
   end

   // A recorded load rd is never zero, so zeroed source fields cannot match it.
   assign hazard    = in_valid && load_rec_valid &&
                      (dec.rs1 == load_rec_rd || dec.rs2 == load_rec_rd);
   assign out_valid = (count != '0);
   assign full      = (count == FULL_CNT);
   assign pop       = out_valid && out_ready;
   assign in_ready  = (!full || pop) && !hazard;
   assign push      = in_valid && in_ready;

   always_comb begin
      rd_ptr_next = pop ? ptr_inc(rd_ptr) : rd_ptr;
      remain      = pop ? count - CNT_BITS'(1) : count;
      count_next  = push ? remain + CNT_BITS'(1) : remain;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= dec;
   end

   // The head register mirrors the oldest entry and keeps the last popped bundle when empty.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         if (remain != '0)
            head_q <= mem[rd_ptr_next];
         else if (push)
            head_q <= dec;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         load_rec_valid <= 1'b0;
         load_rec_rd    <= '0;
         bubble_cnt     <= '0;
      end else if (hazard) begin
         load_rec_valid <= 1'b0;
         if (bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else if (push) begin
         load_rec_valid <= (dec.opcode == OP_LOAD) && (dec.rd != 5'd0);
         load_rec_rd    <= dec.rd;
      end
   end

   assign opcode     = head_q.opcode;
   assign funct3     = head_q.funct3;
   assign funct7     = head_q.funct7;
   assign rs1        = head_q.rs1;
   assign rs2        = head_q.rs2;
   assign rd         = head_q.rd;
   assign imm        = head_q.imm;
   assign alu_src    = head_q.alu_src;
   assign mem_to_reg = head_q.mem_to_reg;
   assign mem_write  = head_q.mem_write;
   assign reg_write  = head_q.reg_write;
   assign branch     = head_q.branch;
   assign jump       = head_q.jump;
`ifdef DECODE_ILLEGAL_EN
   assign illegal    = head_q.illegal;
`endif

endmodule
